// File: rtl/addn_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is split into SEG-bit
// segments, one segment resolved per stage, with a valid/ready handshake at both ends.
module addn_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    function automatic logic [SEG:0] add_seg(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c);
        return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
    endfunction

    // Stage registers: index k holds the beat after segment k has been added.
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] s_p   [STAGES];
    logic             c_p   [STAGES];
    logic             vld_p [STAGES];
    logic             ovf_p;

    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];

    logic [WIDTH-1:0] s_n   [STAGES];
    logic             c_n   [STAGES];
    logic             ovf_n;
    logic [SEG:0]     seg_r;
    logic             stall;

    assign stall    = vld_p[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        // Capture: subtraction becomes a + ~b + ~cin right at the input.
        src_a[0] = a;
        src_b[0] = b ^ {WIDTH{sub}};
        src_s[0] = '0;
        src_c[0] = cin ^ sub;
        src_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_p[k-1];
            src_b[k] = b_p[k-1];
            src_s[k] = s_p[k-1];
            src_c[k] = c_p[k-1];
            src_v[k] = vld_p[k-1];
        end
        seg_r = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg_r  = add_seg(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_c[k]);
            s_n[k] = src_s[k];
            s_n[k][k*SEG +: SEG] = seg_r[SEG-1:0];
            c_n[k] = seg_r[SEG];
        end
        // a ^ b ^ s at the MSB recovers the carry into the MSB.
        ovf_n = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
              ^ s_n[STAGES-1][WIDTH-1] ^ c_n[STAGES-1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < STAGES; k++) begin
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                s_p[k]   <= '0;
                c_p[k]   <= 1'b0;
                vld_p[k] <= 1'b0;
            end
            ovf_p <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_p[k]   <= src_a[k];
                b_p[k]   <= src_b[k];
                s_p[k]   <= s_n[k];
                c_p[k]   <= c_n[k];
                vld_p[k] <= src_v[k];
            end
            ovf_p <= ovf_n;
        end
    end

    // Output stage: the last stage register drives the result directly.
    assign out_valid = vld_p[STAGES-1];
    assign sum       = s_p[STAGES-1];
    assign cout      = c_p[STAGES-1];
    assign ovf       = ovf_p;

endmodule

// File: tb/tb_addn_pipe.sv
// Directed bench for addn_pipe: a 4-stage (SEG=4) and a 1-stage (SEG=16) instance
// share stimulus; each is tracked by its own occupancy model and result queue.
module tb_addn_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;

    logic        in_ready0, out_valid0, cout0, ovf0;
    logic [15:0] sum0;
    logic        in_ready1, out_valid1, cout1, ovf1;
    logic [15:0] sum1;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  mv0;
    logic        mv1;
    logic [17:0] q0[$];
    logic [17:0] q1[$];

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [17:0] ve [8];

    always #5 clk = ~clk;

    addn_pipe #(.WIDTH(16), .SEG(4)) dut0 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid0),
        .out_ready(out_ready), .sum(sum0), .cout(cout0), .ovf(ovf0)
    );

    addn_pipe #(.WIDTH(16), .SEG(16)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid1),
        .out_ready(out_ready), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    function automatic logic [17:0] ex(input logic o, input logic c, input logic [15:0] s);
        return {o, c, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check at negedge, advance models on the edge.
    task automatic step(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                        input logic c, input logic s, input logic [17:0] e,
                        input logic ordy, output logic acc);
        logic st0, st1;
        logic [17:0] r;
        in_valid = v; a = aa; b = bb; cin = c; sub = s; out_ready = ordy;
        @(negedge clk);
        st0 = mv0[3] & ~ordy;
        st1 = mv1 & ~ordy;
        chk("ovld0", {31'd0, out_valid0}, {31'd0, mv0[3]});
        chk("irdy0", {31'd0, in_ready0}, {31'd0, ~st0});
        chk("ovld1", {31'd0, out_valid1}, {31'd0, mv1});
        chk("irdy1", {31'd0, in_ready1}, {31'd0, ~st1});
        if (mv0[3] && ordy) begin
            if (q0.size() == 0) chk("res0_unexpected", 32'd1, 32'd0);
            else begin r = q0.pop_front(); chk("res0", {14'd0, ovf0, cout0, sum0}, {14'd0, r}); end
        end
        if (mv1 && ordy) begin
            if (q1.size() == 0) chk("res1_unexpected", 32'd1, 32'd0);
            else begin r = q1.pop_front(); chk("res1", {14'd0, ovf1, cout1, sum1}, {14'd0, r}); end
        end
        if (v && !st0) q0.push_back(e);
        if (v && !st1) q1.push_back(e);
        acc = v & ~st0;
        @(posedge clk);
        if (!st0) mv0 = {mv0[2:0], v};
        if (!st1) mv1 = v;
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++)
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 18'h0, 1'b1, acc);
        chk("drain0_left", q0.size(), 32'd0);
        chk("drain1_left", q1.size(), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ovld0"}, {31'd0, out_valid0}, 32'd0);
        chk({tag, "_res0"}, {14'd0, ovf0, cout0, sum0}, 32'd0);
        chk({tag, "_irdy0"}, {31'd0, in_ready0}, 32'd1);
        chk({tag, "_ovld1"}, {31'd0, out_valid1}, 32'd0);
        chk({tag, "_res1"}, {14'd0, ovf1, cout1, sum1}, 32'd0);
        chk({tag, "_irdy1"}, {31'd0, in_ready1}, 32'd1);
    endtask

    initial begin
        logic acc;
        int idx;
        va = '{16'h1234, 16'h00FF, 16'h8000, 16'h0F0F, 16'h0000, 16'hABCD, 16'h4000, 16'hFFFF};
        vb = '{16'h1111, 16'h0001, 16'h0001, 16'hF0F0, 16'h0000, 16'h0000, 16'h4000, 16'hFFFF};
        vc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ve = '{ex(0, 0, 16'h2345), ex(0, 0, 16'h0101), ex(1, 1, 16'h7FFF), ex(0, 1, 16'h0000),
               ex(0, 0, 16'hFFFF), ex(0, 0, 16'hABCD), ex(1, 0, 16'h8000), ex(0, 1, 16'h0000)};
        rstn = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        mv0 = '0; mv1 = 1'b0;
        #3;
        chk_zero("por");
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic corners, including latency through the model.
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, ex(0, 1, 16'h0000), 1'b1, acc);
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, ex(1, 0, 16'h8000), 1'b1, acc);
        step(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, ex(1, 1, 16'h0000), 1'b1, acc);
        step(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, ex(0, 0, 16'hFFFE), 1'b1, acc);
        step(1'b1, 16'h0005, 16'h0003, 1'b1, 1'b1, ex(0, 1, 16'h0001), 1'b1, acc);
        drain();

        // Back-pressure: out_ready low for cycles 5..7, beats held until accepted.
        idx = 0;
        for (int cyc = 0; cyc < 40 && (idx < 8 || q0.size() != 0 || q1.size() != 0); cyc++) begin
            if (idx < 8) begin
                step(1'b1, va[idx], vb[idx], vc[idx], vs[idx], ve[idx], !(cyc >= 5 && cyc <= 7), acc);
                if (acc) idx++;
            end else begin
                step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 18'h0, 1'b1, acc);
            end
        end
        chk("bp_all_accepted", idx, 32'd8);
        drain();

        // Bubbles: alternating in_valid must come out with the gaps intact.
        for (int i = 0; i < 8; i++)
            step(i % 2 == 0, va[i], vb[i], vc[i], vs[i], ve[i], 1'b1, acc);
        drain();

        // Reset with beats in flight and a result on the output.
        for (int i = 0; i < 4; i++)
            step(1'b1, va[i], vb[i], vc[i], vs[i], ve[i], 1'b1, acc);
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_zero("rst_mid");
        q0.delete(); q1.delete(); mv0 = '0; mv1 = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk_zero("rst_hold");
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++)
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 18'h0, 1'b1, acc);
        step(1'b1, va[5], vb[5], vc[5], vs[5], ve[5], 1'b1, acc);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
